seven_seg_scan: RTL and testbench
=================================

Name: seven_seg_scan

Overview:
- Time-multiplexing scan controller for a multi-digit common-anode 7-segment display.
- Sequences NUM_DIGITS hex nibbles through one shared hex-to-7-segment decoder. The decoder drives active-low segment lines A..G; its output for nibble 8 is 7'b0000000.
- Drives active-low anode enables, one digit at a time, with a blanking guard between digits to prevent ghosting.
- Updates the displayed value only on a frame boundary, so the display never shows a torn value.

Parameters:
- NUM_DIGITS, 4: number of digits scanned; must be ≥ 2.
- REFRESH_DIV, 50000: clock cycles per digit slot, including blanking.
- BLANK_CYCLES, 16: cycles at the start of each slot with all anodes off; must satisfy 1 ≤ BLANK_CYCLES < REFRESH_DIV.
- IDX_W, $clog2(NUM_DIGITS): width of the digit index.

Ports:
- clk, input, 1: system clock, rising edge.
- rst, input, 1: asynchronous, active-high reset.
- en, input, 1: scan enable; 0 means display off.
- load, input, 1: single-cycle strobe that captures value into the shadow register.
- value, input, 4*NUM_DIGITS: digit nibbles; digit i = value[4*i+3:4*i].
- digit_en, input, NUM_DIGITS: per-digit enable; 0 keeps that digit dark.
- code, output, 4: nibble for the shared decoder's input.
- an, output, NUM_DIGITS: anode enables, active-low.
- dig_idx, output, IDX_W: index of the current slot.
- frame_done, output, 1: one-cycle pulse after the last slot completes.
- pending, output, 1: a loaded value is waiting for the next frame boundary.

Behaviour:
- Reset (async, rst=1) sets:
  - an = all 1s; code = 0; dig_idx = 0; frame_done = 0; pending = 0.
  - shadow = 0; active = 0; cnt = 0; state = BLANK.
- All outputs are registered. No combinational path exists from inputs to outputs.
- State machine, per slot, when en=1:
  - BLANK: an = all 1s; cnt counts 0..BLANK_CYCLES-1; then go to SHOW.
  - SHOW: an[dig_idx] = ~digit_en[dig_idx], all other bits = 1; cnt continues to REFRESH_DIV-1.
  - At the end of SHOW: cnt → 0, dig_idx increments, state → BLANK.
- code = active[dig_idx] nibble. It is updated on entry to BLANK, so it is stable BLANK_CYCLES cycles before the anode turns on.
- Slot timing: each slot is exactly REFRESH_DIV cycles, with an[i] low for exactly REFRESH_DIV-BLANK_CYCLES consecutive cycles. A disabled digit still consumes its slot.
- Wrap-around: when dig_idx=NUM_DIGITS-1 and the slot ends:
  - dig_idx → 0.
  - frame_done = 1 for exactly the next cycle.
  - If pending, active ← shadow and pending → 0.
- load=1 on any cycle: shadow ← value, pending → 1. A repeated load before the boundary overwrites shadow (last load wins).
- load=1 in the same cycle as a frame boundary: active ← value directly, pending stays 0.
- en=0, synchronous:
  - Forces state = BLANK, cnt = 0, dig_idx = 0, an = all 1s, frame_done = 0.
  - load is still accepted. If pending, active ← shadow on the next cycle and pending clears.
- en 0→1: the scan restarts at slot 0 BLANK. The first anode goes low BLANK_CYCLES cycles after en is sampled high.
- rst mid-frame: immediate return to the reset values listed above. Shadow and active contents are lost.

Test Plan:
- Test parameters: NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2.
- Reset, then en=1, load=1 with value=16'h4321:
  - First frame shows 0000; frame_done pulses after 32 cycles.
  - Next frame: code = 1, 2, 3, 4 in slots 0–3.
  - an sequence 1110, 1101, 1011, 0111, each low 6 cycles, separated by 2 cycles of 1111.
- digit_en=4'b1010, value=16'hABCD → an[0] and an[2] never go low; slots 1 and 3 display C and A; the frame period stays 32 cycles.
- Two loads mid-frame (16'h1111, then 16'h2222) → pending=1 until the boundary; the next frame displays 2222; pending clears in the cycle frame_done rises.
- load=16'h5555 coincident with the wrap cycle → the next frame displays 5555; pending never asserts.
- en=0 mid-SHOW of slot 2 → the next cycle an=1111 and dig_idx=0. Re-enable → an[0] low after 2 cycles.
- rst asserted asynchronously mid-slot (no clock edge) → an=1111, code=0, pending=0 immediately. After release with en=1, slot 0 shows 0.

Source files
------------

// File: rtl/seven_seg_scan.sv
// ============================================================================
// Module   : seven_seg_scan
// Purpose  : Multiplexed scan controller for a common-anode 7-segment display
//            with per-slot blanking and frame-synchronous value update.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seven_seg_scan #(
   parameter int NUM_DIGITS   = 4,
   parameter int REFRESH_DIV  = 50000,
   parameter int BLANK_CYCLES = 16,
   parameter int IDX_W        = $clog2(NUM_DIGITS)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic [NUM_DIGITS-1:0]   digit_en,
   output logic [3:0]              code,
   output logic [NUM_DIGITS-1:0]   an,
   output logic [IDX_W-1:0]        dig_idx,
   output logic                    frame_done,
   output logic                    pending
);

   localparam int CNT_W = $clog2(REFRESH_DIV);

   localparam logic [CNT_W-1:0] c_cnt_last   = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0] c_blank_last = CNT_W'(BLANK_CYCLES - 1);
   localparam logic [IDX_W-1:0] c_idx_last   = IDX_W'(NUM_DIGITS - 1);

   typedef enum logic [0:0] {
      BLANK = 1'b0,
      SHOW  = 1'b1
   } state_t;

   state_t                  r_state;
   logic [CNT_W-1:0]        r_cnt;
   logic [4*NUM_DIGITS-1:0] r_shadow;
   logic [4*NUM_DIGITS-1:0] r_active;

   logic                    w_slot_end;
   logic                    w_blank_end;
   logic                    w_wrap;
   logic [IDX_W-1:0]        w_idx_next;
   logic [IDX_W-1:0]        w_code_idx;
   logic [4*NUM_DIGITS-1:0] w_active_next;
   logic [NUM_DIGITS-1:0]   w_show_an;
   logic [3:0]              w_code_next;

   assign w_slot_end  = (r_state == SHOW) && (r_cnt == c_cnt_last);
   assign w_blank_end = (r_state == BLANK) && (r_cnt == c_blank_last);
   assign w_wrap      = w_slot_end && (dig_idx == c_idx_last);
   assign w_idx_next  = w_wrap ? '0 : dig_idx + 1'b1;
   assign w_code_idx  = en ? w_idx_next : '0;

   // A load coinciding with the frame boundary bypasses the shadow register.
   always_comb begin
      w_active_next = r_active;
      if (!en) begin
         if (pending) w_active_next = r_shadow;
      end else if (w_wrap) begin
         if (load)         w_active_next = value;
         else if (pending) w_active_next = r_shadow;
      end
   end

   always_comb begin
      w_show_an          = '1;
      w_show_an[dig_idx] = ~digit_en[dig_idx];
   end

   always_comb begin
      w_code_next = 4'd0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (w_code_idx == IDX_W'(i)) w_code_next = w_active_next[4*i +: 4];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= BLANK;
         r_cnt      <= '0;
         r_shadow   <= '0;
         r_active   <= '0;
         an         <= '1;
         code       <= 4'd0;
         dig_idx    <= '0;
         frame_done <= 1'b0;
         pending    <= 1'b0;
      end else begin
         r_active   <= w_active_next;
         frame_done <= 1'b0;
         if (load) r_shadow <= value;

         if (!en) begin
            r_state <= BLANK;
            r_cnt   <= '0;
            dig_idx <= '0;
            an      <= '1;
            code    <= w_code_next;
            pending <= load;
         end else begin
            case (r_state)
               BLANK: begin
                  r_cnt <= r_cnt + 1'b1;
                  if (w_blank_end) begin
                     r_state <= SHOW;
                     an      <= w_show_an;
                  end
               end
               SHOW: begin
                  if (w_slot_end) begin
                     r_state    <= BLANK;
                     r_cnt      <= '0;
                     dig_idx    <= w_idx_next;
                     an         <= '1;
                     code       <= w_code_next;
                     frame_done <= w_wrap;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                     an    <= w_show_an;
                  end
               end
               default: r_state <= BLANK;
            endcase

            if (w_wrap)    pending <= 1'b0;
            else if (load) pending <= 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_seven_seg_scan.sv
// ============================================================================
// Module   : tb_seven_seg_scan
// Purpose  : Directed self-checking bench for seven_seg_scan (4 digits,
//            8-cycle slots, 2-cycle blanking).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seven_seg_scan;

   logic        clk;
   logic        rst;
   logic        en;
   logic        load;
   logic [15:0] value;
   logic [3:0]  digit_en;
   logic [3:0]  code;
   logic [3:0]  an;
   logic [1:0]  dig_idx;
   logic        frame_done;
   logic        pending;

   int checks = 0;
   int errors = 0;

   seven_seg_scan #(
      .NUM_DIGITS  (4),
      .REFRESH_DIV (8),
      .BLANK_CYCLES(2)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .load      (load),
      .value     (value),
      .digit_en  (digit_en),
      .code      (code),
      .an        (an),
      .dig_idx   (dig_idx),
      .frame_done(frame_done),
      .pending   (pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
      checks++;
      assert (obs === exp_v)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   // Frame position p (0..31) counts clock edges since the last wrap edge;
   // slot = p/8, anode low in phases 2..7 of the slot.
   task automatic check_frame(input logic [15:0] val, input logic [3:0] den,
                              input int start, input int stop, input logic pend);
      for (int p = start; p <= stop; p++) begin
         int         s;
         int         ph;
         logic [3:0] ea;
         s  = p / 8;
         ph = p % 8;
         ea = 4'b1111;
         if (ph >= 2) ea[s] = ~den[s];
         chk("an", 16'(an), 16'(ea));
         chk("code", 16'(code), (val >> (4 * s)) & 16'h000F);
         chk("dig_idx", 16'(dig_idx), 16'(s));
         chk("frame_done", 16'(frame_done), 16'(p == 0));
         chk("pending", 16'(pending), 16'(pend));
         @(negedge clk);
      end
   endtask

   initial begin
      rst      = 1'b1;
      en       = 1'b0;
      load     = 1'b0;
      value    = 16'h0000;
      digit_en = 4'b1111;
      #1;
      chk("rst_an", 16'(an), 16'h000F);
      chk("rst_code", 16'(code), 16'h0);
      chk("rst_idx", 16'(dig_idx), 16'h0);
      chk("rst_fd", 16'(frame_done), 16'h0);
      chk("rst_pend", 16'(pending), 16'h0);

      // First frame shows zeros while 4321 waits for the boundary
      @(negedge clk);
      rst   = 1'b0;
      en    = 1'b1;
      load  = 1'b1;
      value = 16'h4321;
      @(negedge clk);
      load = 1'b0;
      check_frame(16'h0000, 4'b1111, 1, 31, 1'b1);
      // Frame with 4321; switch to digit_en=1010 and queue ABCD
      digit_en = 4'b1010;
      load     = 1'b1;
      value    = 16'hABCD;
      check_frame(16'h4321, 4'b1010, 0, 0, 1'b0);
      load = 1'b0;
      check_frame(16'h4321, 4'b1010, 1, 31, 1'b1);
      check_frame(16'hABCD, 4'b1010, 0, 31, 1'b0);

      // Two loads mid-frame: last one wins
      digit_en = 4'b1111;
      load     = 1'b1;
      value    = 16'h1111;
      check_frame(16'hABCD, 4'b1111, 0, 0, 1'b0);
      load = 1'b0;
      check_frame(16'hABCD, 4'b1111, 1, 2, 1'b1);
      load  = 1'b1;
      value = 16'h2222;
      check_frame(16'hABCD, 4'b1111, 3, 3, 1'b1);
      load = 1'b0;
      check_frame(16'hABCD, 4'b1111, 4, 31, 1'b1);
      check_frame(16'h2222, 4'b1111, 0, 30, 1'b0);

      // Load on the wrap cycle goes straight to the display
      load  = 1'b1;
      value = 16'h5555;
      check_frame(16'h2222, 4'b1111, 31, 31, 1'b0);
      load = 1'b0;
      check_frame(16'h5555, 4'b1111, 0, 19, 1'b0);

      // Disable in mid-SHOW of slot 2
      chk("show2_an", 16'(an), 16'hB);
      en = 1'b0;
      @(negedge clk);
      chk("dis_an", 16'(an), 16'hF);
      chk("dis_idx", 16'(dig_idx), 16'h0);
      chk("dis_fd", 16'(frame_done), 16'h0);
      chk("dis_code", 16'(code), 16'h5);
      load  = 1'b1;
      value = 16'h6789;
      @(negedge clk);
      load = 1'b0;
      chk("dis_pend_set", 16'(pending), 16'h1);
      @(negedge clk);
      chk("dis_pend_clr", 16'(pending), 16'h0);
      chk("dis_code_new", 16'(code), 16'h9);
      en = 1'b1;
      @(negedge clk);
      chk("ren_an_blank", 16'(an), 16'hF);
      @(negedge clk);
      chk("ren_an_on", 16'(an), 16'hE);
      check_frame(16'h6789, 4'b1111, 2, 31, 1'b0);

      // Asynchronous reset in slot 1 with a load pending
      check_frame(16'h6789, 4'b1111, 0, 11, 1'b0);
      load  = 1'b1;
      value = 16'hEEEE;
      check_frame(16'h6789, 4'b1111, 12, 12, 1'b0);
      load = 1'b0;
      chk("pre_rst_pend", 16'(pending), 16'h1);
      chk("pre_rst_code", 16'(code), 16'h8);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_an", 16'(an), 16'hF);
      chk("arst_code", 16'(code), 16'h0);
      chk("arst_pend", 16'(pending), 16'h0);
      chk("arst_idx", 16'(dig_idx), 16'h0);
      @(negedge clk);
      rst = 1'b0;
      chk("post_rst_fd", 16'(frame_done), 16'h0);
      @(negedge clk);
      check_frame(16'h0000, 4'b1111, 1, 31, 1'b0);
      check_frame(16'h0000, 4'b1111, 0, 0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
